// File: rtl/cpu_trace_pkg.sv
// Shared constants, state encoding and ASCII helpers for the CPU trace emitter.
package cpu_trace_pkg;

    localparam logic [7:0] ASC_HAT    = 8'h5E;
    localparam logic [7:0] ASC_AT     = 8'h40;
    localparam logic [7:0] ASC_COLON  = 8'h3A;
    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_STAR   = 8'h2A;
    localparam logic [7:0] ASC_LT     = 8'h3C;
    localparam logic [7:0] ASC_EQ     = 8'h3D;
    localparam logic [7:0] ASC_HASH   = 8'h23;
    localparam logic [7:0] ASC_SP     = 8'h20;

    localparam logic [13:0] TIME_MAX = 14'd9999;

    typedef enum logic [4:0] {
        ST_IDLE, ST_CONV, ST_HAT, ST_TIME, ST_AT, ST_PC, ST_COLON, ST_SP1, ST_TAG,
        ST_REG, ST_ADDR, ST_SP2, ST_LT, ST_EQ, ST_SP3, ST_DATA, ST_HASH
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] dec_ascii(input logic [3:0] dig);
        return 8'h30 + {4'h0, dig};
    endfunction

endpackage

// File: rtl/cpu_trace_emitter_if.sv
// Record handshake and character stream of the CPU trace emitter.
interface cpu_trace_emitter_if;
    logic        rec_valid;
    logic        rec_ready;
    logic        rec_kind;
    logic [13:0] rec_time;
    logic [31:0] rec_pc;
    logic [4:0]  rec_reg;
    logic [31:0] rec_addr;
    logic [31:0] rec_data;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        busy;

    modport slave (
        input  rec_valid, rec_kind, rec_time, rec_pc, rec_reg, rec_addr, rec_data, char_ready,
        output rec_ready, char_out, char_valid, busy
    );

    modport master (
        output rec_valid, rec_kind, rec_time, rec_pc, rec_reg, rec_addr, rec_data, char_ready,
        input  rec_ready, char_out, char_valid, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary to four BCD digits, one shift per cycle.
module bin2bcd_seq (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [13:0]     bin,
    output logic            done,
    output logic [3:0][3:0] bcd
);
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d, adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (start) begin
            bin_d  = bin;
            bcd_d  = '0;
            cnt_d  = 4'd14;
            done_d = 1'b0;
        end else if (cnt_q != 4'd0) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d  = cnt_q - 4'd1;
            done_d = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back record per handshake into a '^time@pc: ... <= data#' ASCII line.
module cpu_trace_emitter
    import cpu_trace_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    cpu_trace_emitter_if.slave tr
);
    state_t      state_q, state_d, adv_state;
    logic [2:0]  idx_q, idx_d, adv_idx, tstart;
    logic        kind_q, kind_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, data_q, data_d;
    logic [4:0]  reg_q, reg_d;
    logic [7:0]  char_out_q, char_out_d, adv_char;
    logic        char_valid_q, char_valid_d;
    logic        rec_ready, accept, bcd_done;
    logic [13:0] time_clamped;
    logic [3:0][3:0] bcd_dig;
    logic [1:0]  reg_tens;
    logic [3:0]  reg_ones;

    assign rec_ready    = !reset && (state_q == ST_IDLE);
    assign accept       = tr.rec_valid && rec_ready;
    assign time_clamped = (tr.rec_time > TIME_MAX) ? TIME_MAX : tr.rec_time;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (time_clamped),
        .done  (bcd_done),
        .bcd   (bcd_dig)
    );

    // Leading-zero suppression: start at the highest nonzero digit, else the units digit.
    assign tstart = (bcd_dig[3] != 4'd0) ? 3'd3 :
                    (bcd_dig[2] != 4'd0) ? 3'd2 :
                    (bcd_dig[1] != 4'd0) ? 3'd1 : 3'd0;

    assign reg_tens = (reg_q >= 5'd30) ? 2'd3 : (reg_q >= 5'd20) ? 2'd2 :
                      (reg_q >= 5'd10) ? 2'd1 : 2'd0;
    assign reg_ones = 4'(reg_q - ({reg_tens, 3'b000} + {2'b00, reg_tens, 1'b0}));

    always_comb begin
        adv_state = state_q;
        adv_idx   = idx_q;
        case (state_q)
            ST_HAT:   begin adv_state = ST_TIME; adv_idx = tstart; end
            ST_TIME:  if (idx_q == 3'd0) adv_state = ST_AT; else adv_idx = idx_q - 3'd1;
            ST_AT:    begin adv_state = ST_PC; adv_idx = 3'd7; end
            ST_PC:    if (idx_q == 3'd0) adv_state = ST_COLON; else adv_idx = idx_q - 3'd1;
            ST_COLON: adv_state = ST_SP1;
            ST_SP1:   adv_state = ST_TAG;
            ST_TAG: begin
                if (kind_q) begin
                    adv_state = ST_ADDR;
                    adv_idx   = 3'd7;
                end else begin
                    adv_state = ST_REG;
                    adv_idx   = (reg_q >= 5'd10) ? 3'd1 : 3'd0;
                end
            end
            ST_REG, ST_ADDR: if (idx_q == 3'd0) adv_state = ST_SP2; else adv_idx = idx_q - 3'd1;
            ST_SP2:   adv_state = ST_LT;
            ST_LT:    adv_state = ST_EQ;
            ST_EQ:    adv_state = ST_SP3;
            ST_SP3:   begin adv_state = ST_DATA; adv_idx = 3'd7; end
            ST_DATA:  if (idx_q == 3'd0) adv_state = ST_HASH; else adv_idx = idx_q - 3'd1;
            ST_HASH:  adv_state = ST_IDLE;
            default:  adv_state = state_q;
        endcase
    end

    always_comb begin
        adv_char = 8'h00;
        case (adv_state)
            ST_HAT:   adv_char = ASC_HAT;
            ST_TIME:  adv_char = dec_ascii(bcd_dig[adv_idx[1:0]]);
            ST_AT:    adv_char = ASC_AT;
            ST_PC:    adv_char = hex_ascii(pc_q[{adv_idx, 2'b00} +: 4]);
            ST_COLON: adv_char = ASC_COLON;
            ST_SP1, ST_SP2, ST_SP3: adv_char = ASC_SP;
            ST_TAG:   adv_char = kind_q ? ASC_STAR : ASC_DOLLAR;
            ST_REG:   adv_char = (adv_idx != 3'd0) ? dec_ascii({2'b00, reg_tens}) : dec_ascii(reg_ones);
            ST_ADDR:  adv_char = hex_ascii(addr_q[{adv_idx, 2'b00} +: 4]);
            ST_LT:    adv_char = ASC_LT;
            ST_EQ:    adv_char = ASC_EQ;
            ST_DATA:  adv_char = hex_ascii(data_q[{adv_idx, 2'b00} +: 4]);
            ST_HASH:  adv_char = ASC_HASH;
            default:  adv_char = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        kind_d       = kind_q;
        pc_d         = pc_q;
        reg_d        = reg_q;
        addr_d       = addr_q;
        data_d       = data_q;
        char_out_d   = char_out_q;
        char_valid_d = char_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    kind_d  = tr.rec_kind;
                    pc_d    = tr.rec_pc;
                    reg_d   = tr.rec_reg;
                    addr_d  = tr.rec_addr;
                    data_d  = tr.rec_data;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (bcd_done) begin
                    state_d      = ST_HAT;
                    idx_d        = 3'd0;
                    char_out_d   = ASC_HAT;
                    char_valid_d = 1'b1;
                end
            end
            default: begin
                // The presented character is held until the sink takes it.
                if (char_valid_q && tr.char_ready) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                    if (adv_state == ST_IDLE) char_valid_d = 1'b0;
                    else                      char_out_d   = adv_char;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            kind_q       <= 1'b0;
            pc_q         <= '0;
            reg_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            kind_q       <= kind_d;
            pc_q         <= pc_d;
            reg_q        <= reg_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign tr.rec_ready  = rec_ready;
    assign tr.char_out   = char_out_q;
    assign tr.char_valid = char_valid_q;
    assign tr.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Scoreboard bench for cpu_trace_emitter: expected lines are queued on send, popped per taken character.
module tb_cpu_trace_emitter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    cpu_trace_emitter_if tr();

    cpu_trace_emitter dut (
        .clk   (clk),
        .reset (reset),
        .tr    (tr)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  sb[$];
    int          acc_edge = 0;
    int          first_vld = 0;
    int          hash_edge = 0;
    int          line_pos = 0;
    bit          rand_rdy = 1'b0;
    bit          prev_hold = 1'b0;
    bit          vld_prev = 1'b0;
    logic [7:0]  prev_char = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic string exp_line(input bit k, input int unsigned t, input logic [31:0] pc,
                                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        int unsigned tc;
        tc = (t > 9999) ? 9999 : t;
        if (k) return $sformatf("^%0d@%08x: *%08x <= %08x#", tc, pc, a, d);
        return $sformatf("^%0d@%08x: $%0d <= %08x#", tc, pc, r, d);
    endfunction

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    endtask

    task automatic drive_fields(input bit k, input int unsigned t, input logic [31:0] pc,
                                input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        tr.rec_kind = k;
        tr.rec_time = 14'(t);
        tr.rec_pc   = pc;
        tr.rec_reg  = r;
        tr.rec_addr = a;
        tr.rec_data = d;
    endtask

    task automatic scramble();
        drive_fields(1'($urandom_range(0, 1)), $urandom_range(0, 16383), $urandom,
                     5'($urandom_range(0, 31)), $urandom, $urandom);
    endtask

    task automatic send(input bit k, input int unsigned t, input logic [31:0] pc,
                        input logic [4:0] r, input logic [31:0] a, input logic [31:0] d, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!tr.rec_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rec_ready_wait", 32'(tr.rec_ready), 32'd1);
        drive_fields(k, t, pc, r, a, d);
        tr.rec_valid = 1'b1;
        push_line(exp_line(k, t, pc, r, a, d));
        acc_edge = cyc + 1;
        if (!hold) begin
            @(negedge clk);
            tr.rec_valid = 1'b0;
            scramble();
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb.size() != 0 || tr.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(tr.busy), 32'd0);
    endtask

    initial forever begin
        @(negedge clk);
        tr.char_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Character monitor, sampled mid-low-phase after inputs have settled.
    initial forever begin
        @(negedge clk);
        #2;
        if (reset) begin
            prev_hold = 1'b0;
            vld_prev  = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_char", 32'(tr.char_out), 32'(prev_char));
                chk("hold_valid", 32'(tr.char_valid), 32'd1);
            end
            if (tr.char_valid && !vld_prev) first_vld = cyc;
            if (tr.char_valid && tr.char_ready) begin
                if (sb.size() == 0) chk("unexpected_char", 32'(sb.size()), 32'd1);
                else chk("char", 32'(tr.char_out), 32'(sb.pop_front()));
                line_pos++;
                if (tr.char_out == 8'h23) begin
                    hash_edge = cyc + 1;
                    line_pos  = 0;
                end
            end
            prev_hold = tr.char_valid && !tr.char_ready;
            prev_char = tr.char_out;
            vld_prev  = tr.char_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_b;
        int n;
        tr.rec_valid  = 1'b0;
        tr.char_ready = 1'b1;
        drive_fields(1'b0, 0, 32'h0, 5'd0, 32'h0, 32'h0);

        repeat (3) @(negedge clk);
        chk("rst_char_valid", 32'(tr.char_valid), 32'd0);
        chk("rst_char_out", 32'(tr.char_out), 32'h00);
        chk("rst_busy", 32'(tr.busy), 32'd0);
        chk("rst_rec_ready", 32'(tr.rec_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(tr.rec_ready), 32'd1);

        // Register write, no backpressure: exact latency and 30 gap-free characters.
        send(1'b0, 123, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd, 1'b0);
        wait_done(500);
        chk("lat_first_char", 32'(first_vld), 32'(acc_edge + 15));
        chk("lat_hash_taken", 32'(hash_edge), 32'(acc_edge + 45));

        send(1'b1, 0, 32'h0000_3004, 5'd0, 32'h0000_0010, 32'hffff_ffff, 1'b0);
        wait_done(500);

        send(1'b0, 12000, 32'h1234_5678, 5'd31, 32'h0, 32'hdead_beef, 1'b0);
        wait_done(500);

        rand_rdy = 1'b1;
        send(1'b0, 123, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd, 1'b0);
        wait_done(3000);
        send(1'b1, 9999, 32'hcafe_f00d, 5'd0, 32'h89ab_cdef, 32'h0123_4567, 1'b0);
        wait_done(3000);
        rand_rdy = 1'b0;

        for (int i = 0; i < 4; i++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, 16383), $urandom,
                 5'($urandom_range(0, 31)), $urandom, $urandom, 1'b0);
            wait_done(500);
        end

        // Back-to-back: rec_valid stays high, second record waits for IDLE.
        send(1'b0, 7, 32'h0000_0040, 5'd10, 32'h0, 32'h0000_0001, 1'b1);
        @(negedge clk);
        drive_fields(1'b1, 45, 32'h0000_0044, 5'd0, 32'h0000_0100, 32'h0000_0002);
        push_line(exp_line(1'b1, 45, 32'h0000_0044, 5'd0, 32'h0000_0100, 32'h0000_0002));
        n = 0;
        @(negedge clk);
        while (!tr.rec_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc_b = cyc + 1;
        chk("b2b_accept_edge", 32'(acc_b), 32'(hash_edge + 1));
        @(negedge clk);
        tr.rec_valid = 1'b0;
        scramble();
        wait_done(500);

        // Reset in the middle of the PC digits.
        send(1'b0, 123, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd, 1'b0);
        n = 0;
        while (line_pos < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_pc_digits", 32'(line_pos >= 7), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_char_valid", 32'(tr.char_valid), 32'd0);
        chk("midrst_busy", 32'(tr.busy), 32'd0);
        chk("midrst_rec_ready", 32'(tr.rec_ready), 32'd0);
        sb.delete();
        line_pos = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", 32'(tr.rec_ready), 32'd1);
        send(1'b1, 321, 32'h0000_2000, 5'd0, 32'h0000_0abc, 32'h8000_0001, 1'b0);
        wait_done(500);
        chk("post_rst_latency", 32'(first_vld), 32'(acc_edge + 15));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
